// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : VeriRisc opcode and phase constants shared by sequencer and benches
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam logic [2:0] HLT = 3'd0;
   localparam logic [2:0] SKZ = 3'd1;
   localparam logic [2:0] ADD = 3'd2;
   localparam logic [2:0] AND = 3'd3;
   localparam logic [2:0] XOR = 3'd4;
   localparam logic [2:0] LDA = 3'd5;
   localparam logic [2:0] STO = 3'd6;
   localparam logic [2:0] JMP = 3'd7;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   function automatic logic is_aluop(input logic [2:0] op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_controller_if.sv
// ============================================================================
// seq_controller_if : opcode/flag inputs, step handshake and datapath strobes
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface seq_controller_if #(
   parameter int STEP_CNT_W = 16
);
   logic [2:0]            opcode;
   logic                  zero;
   logic                  step_mode;
   logic                  step_req;
   logic                  step_ack;
   logic                  sel;
   logic                  rd;
   logic                  ld_ir;
   logic                  inc_pc;
   logic                  ld_pc;
   logic                  ld_ac;
   logic                  wr;
   logic                  data_e;
   logic                  halt;
   logic [2:0]            phase;
   logic [STEP_CNT_W-1:0] instr_cnt;

   modport slave (
      input  opcode, zero, step_mode, step_req,
      output step_ack, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e,
             halt, phase, instr_cnt
   );

   modport master (
      output opcode, zero, step_mode, step_req,
      input  step_ack, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e,
             halt, phase, instr_cnt
   );
endinterface

`default_nettype wire

// File: rtl/seq_controller_phase_counter.sv
// ============================================================================
// phase_counter : 3-bit wrapping phase ring with advance enable
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module phase_counter (
   input  wire logic       clock,
   input  wire logic       reset_req,
   input  wire logic       advance_i,
   output logic [2:0]      phase_o
);
   logic [2:0] phase_q;
   logic [2:0] phase_d;

   assign phase_d = advance_i ? phase_q + 3'd1 : phase_q;

   always_ff @(posedge clock or negedge reset_req) begin
      if (!reset_req) phase_q <= 3'd0;
      else            phase_q <= phase_d;
   end

   assign phase_o = phase_q;
endmodule

`default_nettype wire

// File: rtl/seq_controller.sv
// ============================================================================
// seq_controller : VeriRisc phase sequencer, strobe decode, halt and stepping
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seq_controller
   import cpu_pkg::*;
#(
   parameter int STEP_CNT_W = 16
) (
   input  wire logic        clock,
   input  wire logic        reset_req,
   seq_controller_if.slave  bus
);
   logic [2:0]            phase_w;
   phase_e                ph;
   logic                  halt_q,  halt_d;
   logic                  ack_q,   ack_d;
   logic                  armed_q, armed_d;
   logic                  run_q,   run_d;
   logic [STEP_CNT_W-1:0] cnt_q,   cnt_d;
   logic                  stall, advance, launch, retire, aluop;

   assign ph      = phase_e'(phase_w);
   assign aluop   = is_aluop(bus.opcode);
   // A held step_req only launches once: armed is consumed at launch.
   assign stall   = (ph == INST_ADDR) && bus.step_mode && !(bus.step_req && armed_q);
   assign advance = !halt_q && !stall;
   assign launch  = (ph == INST_ADDR) && advance && bus.step_mode;
   assign retire  = (ph == STORE) && advance;

   phase_counter u_phase (
      .clock     (clock),
      .reset_req (reset_req),
      .advance_i (advance),
      .phase_o   (phase_w)
   );

   always_comb begin
      halt_d  = halt_q;
      armed_d = armed_q;
      run_d   = run_q;
      ack_d   = retire && run_q;
      cnt_d   = cnt_q;
      if ((ph == OP_ADDR) && advance && (bus.opcode == HLT)) halt_d = 1'b1;
      if (!bus.step_req)  armed_d = 1'b1;
      else if (launch)    armed_d = 1'b0;
      if (launch)         run_d = 1'b1;
      else if (retire)    run_d = 1'b0;
      if (retire)         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_req) begin
      if (!reset_req) begin
         halt_q  <= 1'b0;
         ack_q   <= 1'b0;
         armed_q <= 1'b0;
         run_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         halt_q  <= halt_d;
         ack_q   <= ack_d;
         armed_q <= armed_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      bus.sel    = 1'b0;
      bus.rd     = 1'b0;
      bus.ld_ir  = 1'b0;
      bus.inc_pc = 1'b0;
      bus.ld_pc  = 1'b0;
      bus.ld_ac  = 1'b0;
      bus.wr     = 1'b0;
      bus.data_e = 1'b0;
      if (!halt_q) begin
         unique case (ph)
            INST_ADDR:  bus.sel = 1'b1;
            INST_FETCH: begin bus.sel = 1'b1; bus.rd = 1'b1; end
            INST_LOAD, IDLE: begin
               bus.sel   = 1'b1;
               bus.rd    = 1'b1;
               bus.ld_ir = 1'b1;
            end
            OP_ADDR:    bus.inc_pc = 1'b1;
            OP_FETCH:   bus.rd = aluop;
            ALU_OP: begin
               bus.rd     = aluop;
               bus.inc_pc = (bus.opcode == SKZ) && bus.zero;
               bus.ld_pc  = (bus.opcode == JMP);
               bus.data_e = (bus.opcode == STO);
            end
            STORE: begin
               bus.rd     = aluop;
               bus.ld_ac  = aluop;
               bus.ld_pc  = (bus.opcode == JMP);
               bus.inc_pc = (bus.opcode == JMP);
               bus.wr     = (bus.opcode == STO);
               bus.data_e = (bus.opcode == STO);
            end
            default: ;
         endcase
      end
   end

   assign bus.halt      = halt_q;
   assign bus.step_ack  = ack_q;
   assign bus.phase     = phase_w;
   assign bus.instr_cnt = cnt_q;
endmodule

`default_nettype wire
